mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the execute stage.
//  Consumes the EX result (ALU address/result, store data, control) and performs RV32I loads/stores
//  (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/gnt/rvalid data-memory port.
//  Forwards write-back data (load result or ALU result) to the WB stage (WB_we/WB_wr_addr/WB_wr_data).
//  Stalls EX while a memory access is outstanding; one access in flight at a time.
// PARAMETERS
//  DATA_WIDTH  32  datapath and memory word width; only 32 is supported
//  ADDR_WIDTH  5   register-file address width (rd)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  EX_valid_i     in   1   EX presents an instruction this cycle
//  EX_ready_o     out  1   stage can accept; transfer when EX_valid_i & EX_ready_o
//  EX_alu_result_i in  32  ALU result; byte address for loads/stores
//  EX_rs2_data_i  in   32  store data
//  EX_funct3_i    in   3   access size/sign (instr[14:12])
//  EX_mem_read_i  in   1   load
//  EX_mem_write_i in   1   store (mutually exclusive with EX_mem_read_i)
//  EX_reg_write_i in   1   instruction writes rd
//  EX_rd_addr_i   in   ADDR_WIDTH  destination register
//  dmem_req_o     out  1   memory request
//  dmem_we_o      out  1   1 = write, 0 = read
//  dmem_addr_o    out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_be_o      out  4   byte enables (writes only; 4'b0000 on reads)
//  dmem_wdata_o   out  32  lane-replicated write data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   read data valid
//  dmem_rdata_i   in   32  read word
//  MEM_valid_o    out  1   one-cycle pulse per retired instruction
//  WB_we          out  1   register write enable (qualified by MEM_valid_o)
//  WB_wr_addr     out  ADDR_WIDTH  rd
//  WB_wr_data     out  32  write-back data
//  mem_fault_o    out  1   misaligned or illegal-funct3 access (pulses with MEM_valid_o)
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0; EX_ready_o=1 (combinational, EX_ready_o = state==IDLE).
//  FSM IDLE/REQ/WAIT. Transfer at edge N (EX_valid_i & EX_ready_o):
//   - non-memory op: stay IDLE; cycle N+1: MEM_valid_o=1, WB_wr_data=ALU result, WB_we=EX_reg_write_i.
//   - memory op, faulting: no request; cycle N+1: MEM_valid_o=1, mem_fault_o=1, WB_we=0.
//   - memory op, legal: latch all fields -> REQ; dmem_req_o=1 from cycle N+1.
//  REQ: dmem_* held stable until dmem_gnt_i. On gnt: store -> IDLE, next cycle MEM_valid_o=1, WB_we=0;
//   load -> WAIT.
//  WAIT: dmem_rvalid_i ignored outside WAIT (earliest one cycle after gnt). On rvalid -> IDLE; next cycle
//   MEM_valid_o=1, WB_we=latched reg_write, WB_wr_data=formatted load.
//  Min latency: ALU op 1 cycle; store 2 cycles; load 3 cycles. EX may transfer again in the MEM_valid_o cycle.
//  WB_we/WB_wr_addr/WB_wr_data/mem_fault_o are 0 whenever MEM_valid_o=0.
//  Faults: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; funct3 011/110/111 with read, or any
//   funct3[2]=1 with write.
//  Store formatting: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?4'b1100:4'b0011,
//   wdata={2{rs2[15:0]}}; SW be=4'b1111, wdata=rs2.
//  Load formatting: lane = rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  Reset mid-access: dmem_req_o drops immediately (async); access abandoned, no MEM_valid_o.
//   The memory must tolerate a dropped request.
// TESTING
//  1 ALU op, result=300, rd=3, reg_write=1 -> next cycle MEM_valid_o=1, WB_we=1, WB_wr_addr=3,
//    WB_wr_data=300; dmem_req_o never asserted.
//  2 SW addr=0x70, rs2=0xDEADBEEF, gnt in first REQ cycle -> one req cycle, addr=0x70, be=1111,
//    wdata=DEADBEEF, we=1; MEM_valid_o next cycle with WB_we=0.
//  3 LB addr=0x71, gnt delayed 2 cycles, rvalid 1 cycle later, rdata=0x123480FF -> WB_wr_data=0xFFFFFF80;
//    repeat with LBU -> 0x00000080; EX_ready_o=0 from transfer until the MEM_valid_o cycle.
//  4 SH addr=0x72, rs2=0x0000ABCD -> be=1100, wdata=0xABCDABCD; LH addr=0x72, rdata=0x80010000
//    -> 0xFFFF8001.
//  5 LW addr=0x71 -> no dmem_req_o; next cycle MEM_valid_o=1, mem_fault_o=1, WB_we=0.
//  6 rst_n low while in WAIT -> dmem_req_o=0, MEM_valid_o=0, EX_ready_o=1; a following ALU op
//    retires normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// One request is held on the bus until gnt; read data returns later with rvalid.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: executes loads/stores over a req/gnt/rvalid port and forwards
// write-back data to WB, holding EX off while the single access is in flight.
//  state  | meaning
//  IDLE   | accepting from EX; ALU ops and faulting accesses retire next cycle
//  REQ    | request on the bus, fields held stable until gnt
//  WAIT   | load granted, waiting for rvalid
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_valid_i,
  output logic                  EX_ready_o,
  input  logic [DATA_WIDTH-1:0] EX_alu_result_i,
  input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
  input  logic [2:0]            EX_funct3_i,
  input  logic                  EX_mem_read_i,
  input  logic                  EX_mem_write_i,
  input  logic                  EX_reg_write_i,
  input  logic [ADDR_WIDTH-1:0] EX_rd_addr_i,
  mem_access_stage_if.master    dmem,
  output logic                  MEM_valid_o,
  output logic                  WB_we,
  output logic [ADDR_WIDTH-1:0] WB_wr_addr,
  output logic [DATA_WIDTH-1:0] WB_wr_data,
  output logic                  mem_fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;

  logic                  mem_valid_q, mem_valid_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_wr_addr_q, wb_wr_addr_d;
  logic [DATA_WIDTH-1:0] wb_wr_data_q, wb_wr_data_d;
  logic                  mem_fault_q, mem_fault_d;

  logic                  ex_mem_op, ex_misalign, ex_illegal, ex_fault;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_lane, ld_data;

  // Decode of the incoming EX access: fault detection and store lane formatting
  always_comb begin
    ex_mem_op   = EX_mem_read_i | EX_mem_write_i;
    ex_misalign = ((EX_funct3_i[1:0] == 2'b10) && (EX_alu_result_i[1:0] != 2'b00)) ||
                  ((EX_funct3_i[1:0] == 2'b01) && EX_alu_result_i[0]);
    ex_illegal  = (EX_mem_read_i && ((EX_funct3_i == 3'b011) || (EX_funct3_i[2:1] == 2'b11))) ||
                  (EX_mem_write_i && EX_funct3_i[2]);
    ex_fault    = ex_mem_op && (ex_misalign || ex_illegal);

    st_be    = 4'b1111;
    st_wdata = EX_rs2_data_i;
    case (EX_funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << EX_alu_result_i[1:0];
        st_wdata = {4{EX_rs2_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = EX_alu_result_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{EX_rs2_data_i[15:0]}};
      end
      default: ;
    endcase
    if (!EX_mem_write_i) st_be = 4'b0000;
  end

  always_comb begin
    ld_lane = dmem.rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b001:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'b100:  ld_data = {24'd0, ld_lane[7:0]};
      3'b101:  ld_data = {16'd0, ld_lane[15:0]};
      default: ld_data = ld_lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    mem_valid_d  = 1'b0;
    wb_we_d      = 1'b0;
    wb_wr_addr_d = '0;
    wb_wr_data_d = '0;
    mem_fault_d  = 1'b0;
    EX_ready_o   = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (EX_valid_i) begin
          if (ex_mem_op && !ex_fault) begin
            state_d     = S_REQ;
            addr_d      = EX_alu_result_i;
            we_d        = EX_mem_write_i;
            be_d        = st_be;
            wdata_d     = st_wdata;
            funct3_d    = EX_funct3_i;
            reg_write_d = EX_reg_write_i;
            rd_d        = EX_rd_addr_i;
          end else if (ex_fault) begin
            mem_valid_d = 1'b1;
            mem_fault_d = 1'b1;
          end else begin
            mem_valid_d  = 1'b1;
            wb_we_d      = EX_reg_write_i;
            wb_wr_addr_d = EX_rd_addr_i;
            wb_wr_data_d = EX_alu_result_i;
          end
        end
      end
      S_REQ: begin
        if (dmem.gnt) begin
          if (we_q) begin
            state_d     = S_IDLE;
            mem_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem.rvalid) begin
          state_d      = S_IDLE;
          mem_valid_d  = 1'b1;
          wb_we_d      = reg_write_q;
          wb_wr_addr_d = rd_q;
          wb_wr_data_d = ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      mem_valid_q  <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_wr_addr_q <= '0;
      wb_wr_data_q <= '0;
      mem_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      mem_valid_q  <= mem_valid_d;
      wb_we_q      <= wb_we_d;
      wb_wr_addr_q <= wb_wr_addr_d;
      wb_wr_data_q <= wb_wr_data_d;
      mem_fault_q  <= mem_fault_d;
    end
  end

  // Request derives from the state flop so an async reset drops it at once
  assign dmem.req     = (state_q == S_REQ);
  assign dmem.we      = we_q;
  assign dmem.addr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign dmem.be      = be_q;
  assign dmem.wdata   = wdata_q;

  assign MEM_valid_o  = mem_valid_q;
  assign WB_we        = wb_we_q;
  assign WB_wr_addr   = wb_wr_addr_q;
  assign WB_wr_data   = wb_wr_data_q;
  assign mem_fault_o  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: byte-level reference memory predicts
// retire results and bus transactions; a randomized memory responder serves the port.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EX_valid_i = 1'b0;
  logic        EX_ready_o;
  logic [31:0] EX_alu_result_i = '0;
  logic [31:0] EX_rs2_data_i = '0;
  logic [2:0]  EX_funct3_i = '0;
  logic        EX_mem_read_i = 1'b0;
  logic        EX_mem_write_i = 1'b0;
  logic        EX_reg_write_i = 1'b0;
  logic [4:0]  EX_rd_addr_i = '0;
  logic        MEM_valid_o, WB_we, mem_fault_o;
  logic [4:0]  WB_wr_addr;
  logic [31:0] WB_wr_data;

  mem_access_stage_if dmem ();

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_valid_i(EX_valid_i), .EX_ready_o(EX_ready_o),
    .EX_alu_result_i(EX_alu_result_i), .EX_rs2_data_i(EX_rs2_data_i),
    .EX_funct3_i(EX_funct3_i), .EX_mem_read_i(EX_mem_read_i),
    .EX_mem_write_i(EX_mem_write_i), .EX_reg_write_i(EX_reg_write_i),
    .EX_rd_addr_i(EX_rd_addr_i), .dmem(dmem),
    .MEM_valid_o(MEM_valid_o), .WB_we(WB_we), .WB_wr_addr(WB_wr_addr),
    .WB_wr_data(WB_wr_data), .mem_fault_o(mem_fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we_;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
    logic        is_mem;
    int          xfer;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  exp_t        mon_e;
  bus_t        rb, snap;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_edge = 0;
  logic [31:0] last_data = '0;
  logic [4:0]  last_rd = '0;
  logic        last_we = 1'b0;
  logic        last_fault = 1'b0;
  logic [7:0]  ref_mem[0:63];
  logic [31:0] dev_mem[0:15];
  int          force_gnt = -1;
  int          force_rv = -1;
  logic        in_req = 1'b0;
  logic        rv_pend = 1'b0;
  int          gcnt = 0;
  int          rvcnt = 0;
  logic [31:0] rvdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop one expectation per retire; outputs must be quiet otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (MEM_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_we", WB_we, mon_e.we_);
          check("mem_fault", mem_fault_o, mon_e.fault);
          if (mon_e.we_) begin
            check("wb_wr_addr", WB_wr_addr, mon_e.rd);
            check("wb_wr_data", WB_wr_data, mon_e.data);
          end
          check("retire_cycle", cyc, mon_e.is_mem ? done_edge : mon_e.xfer);
          check("ready_at_retire", EX_ready_o, 1'b1);
        end
        last_data  = WB_wr_data;
        last_rd    = WB_wr_addr;
        last_we    = WB_we;
        last_fault = mem_fault_o;
      end else begin
        check("quiet_outputs", {WB_we, mem_fault_o, WB_wr_addr, WB_wr_data}, 64'd0);
      end
    end
  end

  // Memory responder: random gnt delay, random rvalid delay, spurious rvalid when idle
  initial begin
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    forever begin
      @(negedge clk);
      dmem.gnt = 1'b0;
      dmem.rvalid = 1'b0;
      dmem.rdata = $urandom;
      if (!rst_n) begin
        in_req = 1'b0;
        rv_pend = 1'b0;
      end else if (rv_pend) begin
        check("req_in_wait", dmem.req, 1'b0);
        if (rvcnt == 0) begin
          dmem.rvalid = 1'b1;
          dmem.rdata = rvdata;
          rv_pend = 1'b0;
          done_edge = cyc + 1;
        end else rvcnt--;
      end else begin
        if ($urandom_range(0, 3) == 0) dmem.rvalid = 1'b1;
        if (dmem.req) begin
          if (!in_req) begin
            in_req = 1'b1;
            gcnt = (force_gnt >= 0) ? force_gnt : int'($urandom_range(0, 3));
            snap = '{dmem.addr, dmem.we, dmem.be, dmem.wdata};
            if (bus_q.size() == 0) begin
              check("unexpected_req", 64'd1, 64'd0);
            end else begin
              rb = bus_q.pop_front();
              check("bus_addr", dmem.addr, rb.addr);
              check("bus_we", dmem.we, rb.we);
              check("bus_be", dmem.be, rb.be);
              if (rb.we) check("bus_wdata", dmem.wdata, rb.wdata);
            end
          end else begin
            check("bus_stable", {dmem.addr, dmem.we, dmem.be, dmem.wdata[26:0]},
                  {snap.addr, snap.we, snap.be, snap.wdata[26:0]});
          end
          if (gcnt == 0) begin
            dmem.gnt = 1'b1;
            in_req = 1'b0;
            if (dmem.we) begin
              for (int k = 0; k < 4; k++)
                if (dmem.be[k]) dev_mem[dmem.addr[5:2]][8*k +: 8] = dmem.wdata[8*k +: 8];
              done_edge = cyc + 1;
            end else begin
              rv_pend = 1'b1;
              rvcnt = (force_rv >= 0) ? force_rv : int'($urandom_range(0, 2));
              rvdata = dev_mem[dmem.addr[5:2]];
            end
          end else gcnt--;
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    int base;
    base = {26'd0, a[5:2], 2'b00};
    dev_mem[a[5:2]] = v;
    for (int k = 0; k < 4; k++) ref_mem[base + k] = v[8*k +: 8];
  endtask

  // Drive one instruction, wait for the transfer, then predict its outcome
  task automatic issue(input logic rd_, input logic wr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    exp_t        e;
    bus_t        b;
    int          n, bytes, off, base;
    logic        fault;
    logic [31:0] v;
    @(negedge clk);
    EX_mem_read_i = rd_; EX_mem_write_i = wr; EX_reg_write_i = rw; EX_funct3_i = f3;
    EX_alu_result_i = alu; EX_rs2_data_i = rs2; EX_rd_addr_i = rd; EX_valid_i = 1'b1;
    n = 0;
    while (!EX_ready_o && n < 200) begin @(negedge clk); n++; end
    if (!EX_ready_o) begin
      check("ready_timeout", 64'd1, 64'd0);
      EX_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    EX_valid_i = 1'b0;
    bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(alu[1:0]);
    base  = int'(alu[5:0]);
    fault = (rd_ && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (wr && f3[2]) || ((off % bytes) != 0);
    if (!(rd_ || wr)) begin
      e = '{rw, rd, alu, 1'b0, 1'b0, cyc};
    end else if (fault) begin
      e = '{1'b0, 5'd0, 32'd0, 1'b1, 1'b0, cyc};
    end else if (wr) begin
      b.addr = {alu[31:2], 2'b00};
      b.we = 1'b1;
      b.be = 4'b0000;
      for (int i = 0; i < bytes; i++) begin
        b.be[off + i] = 1'b1;
        ref_mem[base + i] = rs2[8*i +: 8];
      end
      b.wdata = (bytes == 1) ? {4{rs2[7:0]}} : (bytes == 2) ? {2{rs2[15:0]}} : rs2;
      bus_q.push_back(b);
      e = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b1, cyc};
    end else begin
      v = '0;
      for (int i = 0; i < bytes; i++) v[8*i +: 8] = ref_mem[base + i];
      if (!f3[2] && bytes < 4 && v[8*bytes-1])
        for (int i = bytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
      b = '{{alu[31:2], 2'b00}, 1'b0, 4'b0000, 32'd0};
      bus_q.push_back(b);
      e = '{rw, rd, v, 1'b0, 1'b1, cyc};
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("retire_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_drop", dmem.req, 1'b0);
    check("rst_ready", EX_ready_o, 1'b1);
    check("rst_valid", MEM_valid_o, 1'b0);
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    check("rst_valid_hold", MEM_valid_o, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kind, off, sz;
    logic [2:0] f3;
    logic wr;
    for (int w = 0; w < 16; w++) preload(32'h1000_0000 | (w << 2), $urandom);

    repeat (3) @(negedge clk);
    check("reset_ready", EX_ready_o, 1'b1);
    check("reset_outputs", {dmem.req, MEM_valid_o, WB_we, mem_fault_o, WB_wr_addr, WB_wr_data}, 64'd0);
    rst_n = 1'b1;

    // ALU op
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'd300, 32'd0, 5'd3);
    wait_idle();
    check("alu_result", {last_we, last_rd, last_data}, {1'b1, 5'd3, 32'd300});

    // SW granted in the first request cycle
    force_gnt = 0;
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h70, 32'hDEADBEEF, 5'd0);
    wait_idle();
    check("sw_mem", dev_mem[12], 32'hDEADBEEF);

    // LB / LBU with delayed gnt and rvalid; EX held off for the whole access
    preload(32'h70, 32'h123480FF);
    force_gnt = 2; force_rv = 0;
    issue(1'b1, 1'b0, 1'b1, 3'b000, 32'h71, 32'd0, 5'd5);
    n = 0;
    @(negedge clk);
    while (!MEM_valid_o && n < 50) begin
      check("ready_low_busy", EX_ready_o, 1'b0);
      n++;
      @(negedge clk);
    end
    check("lb_busy_cycles", n, 4);
    wait_idle();
    check("lb_data", last_data, 32'hFFFFFF80);
    issue(1'b1, 1'b0, 1'b1, 3'b100, 32'h71, 32'd0, 5'd6);
    wait_idle();
    check("lbu_data", last_data, 32'h00000080);

    // LH then SH at the upper half
    force_gnt = -1; force_rv = -1;
    preload(32'h70, 32'h80010000);
    issue(1'b1, 1'b0, 1'b1, 3'b001, 32'h72, 32'd0, 5'd7);
    wait_idle();
    check("lh_data", last_data, 32'hFFFF8001);
    issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h72, 32'h0000ABCD, 5'd0);
    wait_idle();
    check("sh_mem", dev_mem[12], 32'hABCD0000);

    // Misaligned LW faults without a request
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h71, 32'd0, 5'd8);
    wait_idle();
    check("lw_fault", {last_fault, last_we}, {1'b1, 1'b0});

    // Randomized mix, back-to-back
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      off  = $urandom_range(0, 3);
      if (kind <= 2) begin
        issue(1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              5'($urandom_range(0, 31)));
      end else begin
        wr = (kind >= 6 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
        if (kind == 9) begin
          f3 = 3'($urandom_range(0, 7));
          if (wr && f3 == 3'd3) f3 = 3'd2;
        end else if (wr) begin
          f3 = 3'($urandom_range(0, 2));
        end else begin
          sz = $urandom_range(0, 4);
          f3 = (sz < 3) ? 3'(sz) : 3'(sz + 1);
        end
        if (kind != 9) off = (f3[1:0] == 2'b00) ? off : (f3[1:0] == 2'b01) ? (off & 2) : 0;
        issue(!wr, wr, 1'($urandom_range(0, 1)), f3,
              32'h1000_0000 | 32'($urandom_range(0, 15) << 2) | 32'(off), $urandom,
              5'($urandom_range(0, 31)));
      end
    end
    wait_idle();

    // Reset while a load waits for rvalid, then while a request is pending
    force_gnt = 0; force_rv = 8;
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'd0, 5'd9);
    n = 0;
    while (!rv_pend && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    reset_pulse();
    force_gnt = 20; force_rv = -1;
    issue(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0008, 32'd0, 5'd10);
    repeat (2) @(negedge clk);
    check("req_pending", dmem.req, 1'b1);
    reset_pulse();
    force_gnt = -1;
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'd123, 32'd0, 5'd11);
    wait_idle();
    check("post_reset_alu", {last_we, last_rd, last_data}, {1'b1, 5'd11, 32'd123});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
